// File: rtl/counter_seg_display_pkg.sv
// Shared definitions for the two-digit hex 7-segment display stage.
package counter_seg_display_pkg;

    // Display FSM encoding.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHOW_HI = 2'd1,
        SHOW_LO = 2'd2
    } state_t;

    // All segments off.
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Hex digit patterns, bit order g..a. Entry 15 is leftmost.
    localparam logic [15:0][6:0] SEG_PATTERNS = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/counter_seg_display_hex_to_seg7.sv
// Combinational 4-bit hex digit to 7-segment (active-high) decoder.
module hex_to_seg7
    import counter_seg_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Table lookup; every nibble value has a pattern.
    assign o_seg = SEG_PATTERNS[i_nibble];

endmodule

// File: rtl/counter_seg_display.sv
// Accepts one byte per handshake and shows it as two hex digits on one
// 7-segment display: high nibble (dp lit) then low nibble, each for
// HOLD_CYCLES cycles. Ready only while idle, so upstream is paced.
module counter_seg_display
    import counter_seg_display_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] counter_seg_display__input_consumer,
    input  logic       counter_seg_display__input_consumer_vld,
    output logic       counter_seg_display__input_consumer_rdy,
    output logic [6:0] seg,
    output logic       dp
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic [7:0]       r_data,  w_data_nxt;
    logic [6:0]       r_seg,   w_seg_nxt;
    logic             r_dp,    w_dp_nxt;
    logic             w_xfer;
    logic [3:0]       w_nib;
    logic [6:0]       w_pat;

    assign counter_seg_display__input_consumer_rdy = (r_state == IDLE);
    assign w_xfer = counter_seg_display__input_consumer_vld & counter_seg_display__input_consumer_rdy;

    // The only decode ever needed in IDLE is the incoming high nibble; in
    // SHOW_HI it is the stored low nibble, so one decoder suffices.
    assign w_nib = (r_state == IDLE) ? counter_seg_display__input_consumer[7:4] : r_data[3:0];

    hex_to_seg7 u_dec (
        .i_nibble (w_nib),
        .o_seg    (w_pat)
    );

    // Next-state, counter, data and segment logic; everything holds by default.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        w_seg_nxt   = r_seg;
        w_dp_nxt    = r_dp;
        unique case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = SHOW_HI;
                    w_cnt_nxt   = RELOAD;
                    w_data_nxt  = counter_seg_display__input_consumer;
                    w_seg_nxt   = w_pat;
                    w_dp_nxt    = 1'b1;
                end
            end
            SHOW_HI: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_state_nxt = SHOW_LO;
                    w_cnt_nxt   = RELOAD;
                    w_seg_nxt   = w_pat;
                    w_dp_nxt    = 1'b0;
                end
            end
            SHOW_LO: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight byte and blanks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_data  <= 8'h00;
            r_seg   <= SEG_BLANK;
            r_dp    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_seg   <= w_seg_nxt;
            r_dp    <= w_dp_nxt;
        end
    end

    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_counter_seg_display.sv
// Bench for counter_seg_display: one instance with HOLD_CYCLES=4, one with 1.
// Stimulus pushes expected digit pairs; per-instance monitors pop and check
// every displayed cycle once a handshake starts a display.
module tb_counter_seg_display;

    typedef struct packed {
        logic [6:0] hi;
        logic [6:0] lo;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din [2];
    logic       vld [2];
    logic       rdy4, rdy1, dp4, dp1;
    logic [6:0] seg4, seg1;

    exp_t q4[$];
    exp_t q1[$];
    exp_t cur4, cur1;
    int   ph4 = 0, ph1 = 0;
    logic prev4 = 1'b1, prev1 = 1'b1;
    int   pass_cnt = 0, total_cnt = 0;
    int   cyc = 0;

    logic [6:0] PAT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    counter_seg_display #(.HOLD_CYCLES(4)) dut4 (
        .clk                                     (clk),
        .reset                                   (reset),
        .counter_seg_display__input_consumer     (din[0]),
        .counter_seg_display__input_consumer_vld (vld[0]),
        .counter_seg_display__input_consumer_rdy (rdy4),
        .seg                                     (seg4),
        .dp                                      (dp4)
    );

    counter_seg_display #(.HOLD_CYCLES(1)) dut1 (
        .clk                                     (clk),
        .reset                                   (reset),
        .counter_seg_display__input_consumer     (din[1]),
        .counter_seg_display__input_consumer_vld (vld[1]),
        .counter_seg_display__input_consumer_rdy (rdy1),
        .seg                                     (seg1),
        .dp                                      (dp1)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    endtask

    // Checks one displayed cycle: phases 1..h high digit, h+1..2h low digit,
    // 2h+1 ready again with the low digit held.
    task automatic check_phase(input string name, input int h, input int ph, input exp_t cur,
                               input logic [6:0] s, input logic d, input logic r);
        if (ph <= h)
            chk({name, "_hi"}, {7'b0, s, d, r}, {7'b0, cur.hi, 1'b1, 1'b0});
        else if (ph <= 2 * h)
            chk({name, "_lo"}, {7'b0, s, d, r}, {7'b0, cur.lo, 1'b0, 1'b0});
        else
            chk({name, "_done"}, {7'b0, s, d, r}, {7'b0, cur.lo, 1'b0, 1'b1});
    endtask

    // Monitor for the HOLD_CYCLES=4 instance.
    always @(negedge clk) begin
        if (reset) begin
            ph4 = 0; prev4 = 1'b1;
        end else begin
            if (ph4 == 0 && prev4 && !rdy4) begin
                if (q4.size() == 0) begin
                    total_cnt++;
                    $display("FAIL mon4_unexpected: display started with empty queue seg=%h", seg4);
                end else begin
                    cur4 = q4.pop_front();
                    ph4 = 1;
                end
            end
            if (ph4 != 0) begin
                check_phase("mon4", 4, ph4, cur4, seg4, dp4, rdy4);
                ph4 = (ph4 == 9) ? 0 : ph4 + 1;
            end
            prev4 = rdy4;
        end
    end

    // Monitor for the HOLD_CYCLES=1 instance.
    always @(negedge clk) begin
        if (reset) begin
            ph1 = 0; prev1 = 1'b1;
        end else begin
            if (ph1 == 0 && prev1 && !rdy1) begin
                if (q1.size() == 0) begin
                    total_cnt++;
                    $display("FAIL mon1_unexpected: display started with empty queue seg=%h", seg1);
                end else begin
                    cur1 = q1.pop_front();
                    ph1 = 1;
                end
            end
            if (ph1 != 0) begin
                check_phase("mon1", 1, ph1, cur1, seg1, dp1, rdy1);
                ph1 = (ph1 == 3) ? 0 : ph1 + 1;
            end
            prev1 = rdy1;
        end
    end

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send(input int w, input logic [7:0] b, input bit keep, output int t);
        int n = 0;
        din[w] = b;
        vld[w] = 1'b1;
        while (!((w == 0) ? rdy4 : rdy1)) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                total_cnt++;
                $display("FAIL send_timeout: rdy %0d want 1 for byte %h", 0, b);
                break;
            end
        end
        t = cyc;
        @(negedge clk);
        if (!keep) vld[w] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((ph4 != 0 || ph1 != 0 || q4.size() != 0 || q1.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", {15'b0, n < 300}, 16'd1);
    endtask

    initial begin
        int t1, t2, tp, cnt;
        reset  = 1'b1;
        din[0] = 8'h00; din[1] = 8'h00;
        vld[0] = 1'b0;  vld[1] = 1'b0;
        #3;
        chk("rst4", {7'b0, seg4, dp4, rdy4}, {7'b0, 7'h00, 1'b0, 1'b1});
        chk("rst1", {7'b0, seg1, dp1, rdy1}, {7'b0, 7'h00, 1'b0, 1'b1});
        @(posedge clk); #1;
        chk("rst4_hold", {7'b0, seg4, dp4, rdy4}, {7'b0, 7'h00, 1'b0, 1'b1});
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_blank", {7'b0, seg4, dp4, rdy4}, {7'b0, 7'h00, 1'b0, 1'b1});

        // Single byte 3A: 3 -> 4F with dp, A -> 77.
        q4.push_back('{hi: 7'h4F, lo: 7'h77});
        send(0, 8'h3A, 1'b0, t1);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("hold_lo", {7'b0, seg4, dp4, rdy4}, {7'b0, 7'h77, 1'b0, 1'b1});

        // Backpressure: second byte waits 9 cycles; garbage while busy ignored.
        q4.push_back('{hi: 7'h3F, lo: 7'h06});
        q4.push_back('{hi: 7'h3F, lo: 7'h5B});
        send(0, 8'h01, 1'b1, t1);
        repeat (3) begin din[0] = 8'hEE; @(negedge clk); end
        send(0, 8'h02, 1'b0, t2);
        chk("bp_gap", 16'(t2 - t1), 16'd9);
        wait_idle();

        // Upstream counter producer: 00..03 in order.
        q4.push_back('{hi: 7'h3F, lo: 7'h3F});
        q4.push_back('{hi: 7'h3F, lo: 7'h06});
        q4.push_back('{hi: 7'h3F, lo: 7'h5B});
        q4.push_back('{hi: 7'h3F, lo: 7'h4F});
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (cnt < 4) begin
                din[0] = 8'(cnt);
                vld[0] = 1'b1;
                if (rdy4) cnt++;
            end else begin
                vld[0] = 1'b0;
            end
            @(negedge clk);
        end
        vld[0] = 1'b0;
        chk("stream_cnt", 16'(cnt), 16'd4);
        wait_idle();

        // Full decode sweep on HOLD_CYCLES=1 instance, one byte per 3 cycles.
        tp = 0;
        for (int i = 0; i < 16; i++) begin
            q1.push_back('{hi: PAT[i], lo: PAT[i]});
            send(1, {4'(i), 4'(i)}, i < 15, t1);
            if (i > 0) chk("sweep_gap", 16'(t1 - tp), 16'd3);
            tp = t1;
        end
        wait_idle();

        // Reset during SHOW_LO of C5, then 7E after release.
        q4.push_back('{hi: 7'h39, lo: 7'h6D});
        send(0, 8'hC5, 1'b0, t1);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("mid_rst", {7'b0, seg4, dp4, rdy4}, {7'b0, 7'h00, 1'b0, 1'b1});
        @(posedge clk); #1;
        chk("mid_rst_hold", {7'b0, seg4, dp4, rdy4}, {7'b0, 7'h00, 1'b0, 1'b1});
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_blank", {7'b0, seg4, dp4, rdy4}, {7'b0, 7'h00, 1'b0, 1'b1});
        q4.push_back('{hi: 7'h07, lo: 7'h79});
        send(0, 8'h7E, 1'b0, t1);
        wait_idle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1);
    end

endmodule
